dna_readout_regs: RTL and testbench

- Consumes the 57-bit device DNA word from the DNA port reader. That word is all-zero until the read completes, then holds the ID.
- Qualifies the DNA as stable, latches it once and computes a CRC-8 over it serially.
- Exposes the DNA, CRC and status through a simple request/acknowledge register read port for the slow-control bus.

---
 rtl/dna_readout_regs.sv | 185 ++++++++++++++++++
 tb/tb_dna_readout_regs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dna_readout_regs.sv
// -----------------------------------------------------------------------------
// dna_readout_regs
//
// Qualifies the device DNA word delivered by the DNA port reader, latches it
// once it has been seen unchanged and non-zero for STABLE_CYCLES consecutive
// samples, then runs a bit-serial CRC-8 over it (MSB first, init 0x00, no
// final XOR). DNA, CRC and status are readable over a request/acknowledge
// register port with one cycle of latency.
//
// Parameters:
//   DNA_LENGTH    - DNA word width, 33..64
//   STABLE_CYCLES - identical non-zero samples required before latching, >= 1
//   CRC_POLY      - CRC-8 generator polynomial, normal form
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   dna_i     - DNA word, zero while the reader has not finished
//   rd_req    - read request, sampled each rising edge
//   rd_addr   - register address: 0 DNA[31:0], 1 DNA[DNA_LENGTH-1:32],
//               2 status {state, dna_valid, dna_crc}, 3 zero
//   rd_data   - read data, zero whenever rd_ack is low
//   rd_ack    - one-cycle acknowledge, one cycle after the request
//   dna_valid - latched DNA and CRC are final
//   dna_crc   - CRC-8 of the latched DNA, zero until dna_valid
//   busy      - qualifying or computing the CRC
// -----------------------------------------------------------------------------
module dna_readout_regs #(
    parameter int unsigned DNA_LENGTH    = 57,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [7:0]  CRC_POLY      = 8'h07
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DNA_LENGTH-1:0] dna_i,
    input  logic                  rd_req,
    input  logic [1:0]            rd_addr,
    output logic [31:0]           rd_data,
    output logic                  rd_ack,
    output logic                  dna_valid,
    output logic [7:0]            dna_crc,
    output logic                  busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int BIT_W = $clog2(DNA_LENGTH);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_QUALIFY = 2'd1,
        S_CRC     = 2'd2,
        S_READY   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [DNA_LENGTH-1:0]   candidate_q, candidate_d;
    logic [DNA_LENGTH-1:0]   dna_latched_q, dna_latched_d;
    logic [CNT_W-1:0]        stable_cnt_q, stable_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]              crc_q, crc_d;
    logic                    rd_ack_q;
    logic [31:0]             rd_data_q;

    logic [CNT_W-1:0]        stable_inc;
    logic [BIT_W-1:0]        bit_idx;
    logic                    crc_fb;
    logic [63:0]             dna_ext;
    logic [31:0]             status;
    logic [31:0]             rd_mux;

    assign stable_inc = stable_cnt_q + CNT_W'(1);
    // Bits are consumed MSB first, so the counter maps to a descending index.
    assign bit_idx    = BIT_W'(DNA_LENGTH - 1) - bit_cnt_q;
    assign crc_fb     = crc_q[7] ^ dna_latched_q[bit_idx];
    assign dna_ext    = 64'(dna_latched_q);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the read mux relies on this to report the
    // status as it was before the edge that acknowledges the request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_WAIT;
            candidate_q   <= '0;
            dna_latched_q <= '0;
            stable_cnt_q  <= '0;
            bit_cnt_q     <= '0;
            crc_q         <= 8'h00;
            rd_ack_q      <= 1'b0;
            rd_data_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            candidate_q   <= candidate_d;
            dna_latched_q <= dna_latched_d;
            stable_cnt_q  <= stable_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            crc_q         <= crc_d;
            rd_ack_q      <= rd_req;
            rd_data_q     <= rd_req ? rd_mux : 32'h0;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        candidate_d   = candidate_q;
        dna_latched_d = dna_latched_q;
        stable_cnt_d  = stable_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        crc_d         = crc_q;

        case (state_q)
            S_WAIT: begin
                if (dna_i != '0) begin
                    candidate_d  = dna_i;
                    stable_cnt_d = CNT_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        // A single sample is already enough: latch directly.
                        dna_latched_d = dna_i;
                        crc_d         = 8'h00;
                        bit_cnt_d     = '0;
                        state_d       = S_CRC;
                    end else begin
                        state_d = S_QUALIFY;
                    end
                end
            end
            S_QUALIFY: begin
                if (dna_i == '0) begin
                    state_d = S_WAIT;
                end else if (dna_i == candidate_q) begin
                    stable_cnt_d = stable_inc;
                    if (stable_inc == CNT_W'(STABLE_CYCLES)) begin
                        dna_latched_d = candidate_q;
                        crc_d         = 8'h00;
                        bit_cnt_d     = '0;
                        state_d       = S_CRC;
                    end
                end else begin
                    // A different non-zero word restarts qualification.
                    candidate_d  = dna_i;
                    stable_cnt_d = CNT_W'(1);
                end
            end
            S_CRC: begin
                crc_d     = {crc_q[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(DNA_LENGTH - 1)) begin
                    state_d = S_READY;
                end
            end
            default: begin
                // READY is sticky until reset; dna_i is no longer observed.
                state_d = S_READY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        dna_valid = (state_q == S_READY);
        dna_crc   = dna_valid ? crc_q : 8'h00;
        busy      = (state_q == S_QUALIFY) || (state_q == S_CRC);
        status    = {21'b0, state_q, dna_valid, dna_crc};

        case (rd_addr)
            2'd0:    rd_mux = dna_latched_q[31:0];
            2'd1:    rd_mux = dna_ext[63:32];
            2'd2:    rd_mux = status;
            default: rd_mux = 32'h0;
        endcase

        rd_ack  = rd_ack_q;
        rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_dna_readout_regs.sv
// -----------------------------------------------------------------------------
// tb_dna_readout_regs
//
// Directed bench for dna_readout_regs with default parameters. Read-port
// vectors are held in a table of {address, expected data}; the multi-cycle
// scenarios (nominal latency, glitch, drop-out, sticky READY, reset during
// CRC) are written out as sequences. Expected CRCs come from a bit-serial
// CRC-8/0x07 reference function.
// -----------------------------------------------------------------------------
module tb_dna_readout_regs;

    localparam int DNA_LENGTH = 57;
    localparam logic [56:0] DNA_NOM  = 57'h123456789abcdef;
    localparam logic [56:0] DNA_ONES = {57{1'b1}};

    logic                  clock = 1'b0;
    logic                  reset;
    logic [DNA_LENGTH-1:0] dna_i;
    logic                  rd_req;
    logic [1:0]            rd_addr;
    logic [31:0]           rd_data;
    logic                  rd_ack;
    logic                  dna_valid;
    logic [7:0]            dna_crc;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t vecs [4];

    dna_readout_regs dut (
        .clock     (clock),
        .reset     (reset),
        .dna_i     (dna_i),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ack    (rd_ack),
        .dna_valid (dna_valid),
        .dna_crc   (dna_crc),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] crc8_model(input logic [56:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 56; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled
    // 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_edges(input int n, output logic saw_valid);
        saw_valid = 1'b0;
        repeat (n) begin
            tick();
            if (dna_valid) saw_valid = 1'b1;
        end
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        rd_req  = 1'b0;
        rd_addr = 2'd0;
        dna_i   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic read_one(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        check({name, " ack"}, rd_ack, 1);
        check({name, " data"}, rd_data, exp);
    endtask

    initial begin
        logic [7:0] crc_nom;
        logic [7:0] crc_two;
        logic       saw;

        crc_nom = crc8_model(DNA_NOM);
        crc_two = crc8_model(57'h2);

        // ---------------- Nominal ----------------
        apply_reset();
        check("reset dna_valid", dna_valid, 0);
        check("reset dna_crc",   dna_crc,   0);
        check("reset busy",      busy,      0);
        check("reset rd_ack",    rd_ack,    0);
        check("reset rd_data",   rd_data,   0);

        repeat (10) tick();
        check("idle busy", busy, 0);

        dna_i = DNA_NOM;
        tick();                                   // edge 1
        check("qualify busy", busy, 1);
        rd_req  = 1'b1;
        rd_addr = 2'd2;
        tick();                                   // edge 2
        rd_req = 1'b0;
        check("qualify status", rd_data, 32'h0000_0200);
        run_edges(58, saw);                       // edges 3..60
        check("nominal early valid", saw, 0);
        check("crc busy", busy, 1);
        check("crc dna_crc masked", dna_crc, 0);
        rd_req  = 1'b1;
        rd_addr = 2'd2;
        tick();                                   // edge 61
        rd_req = 1'b0;
        check("ready-entry status", rd_data, 32'h0000_0400);
        check("nominal dna_valid", dna_valid, 1);
        check("nominal busy", busy, 0);
        check("nominal dna_crc", dna_crc, crc_nom);

        // Back-to-back reads from the vector table.
        vecs[0] = '{addr: 2'd0, data: 32'h89ab_cdef};
        vecs[1] = '{addr: 2'd1, data: 32'h0123_4567};
        vecs[2] = '{addr: 2'd2, data: {21'b0, 3'b111, crc_nom}};
        vecs[3] = '{addr: 2'd3, data: 32'h0};
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = vecs[i].addr;
            tick();
            check($sformatf("vec%0d ack", i), rd_ack, 1);
            check($sformatf("vec%0d data", i), rd_data, vecs[i].data);
        end
        rd_req = 1'b0;
        tick();
        check("idle ack", rd_ack, 0);
        check("idle data", rd_data, 0);

        // ---------------- Sticky READY ----------------
        dna_i = DNA_ONES;
        repeat (5) tick();
        dna_i = '0;
        repeat (5) tick();
        check("sticky dna_valid", dna_valid, 1);
        check("sticky dna_crc", dna_crc, crc_nom);
        read_one(2'd0, 32'h89ab_cdef, "sticky addr0");
        read_one(2'd1, 32'h0123_4567, "sticky addr1");

        // ---------------- Glitch ----------------
        apply_reset();
        dna_i = 57'h1;
        tick();
        tick();
        dna_i = 57'h2;
        run_edges(60, saw);
        check("glitch early valid", saw, 0);
        tick();
        check("glitch dna_valid", dna_valid, 1);
        check("glitch dna_crc", dna_crc, crc_two);
        read_one(2'd0, 32'h0000_0002, "glitch addr0");
        read_one(2'd1, 32'h0, "glitch addr1");

        // ---------------- Drop-out ----------------
        apply_reset();
        dna_i = 57'h5;
        tick();
        tick();
        check("dropout qualify busy", busy, 1);
        dna_i = '0;
        tick();
        check("dropout busy", busy, 0);
        read_one(2'd2, 32'h0, "dropout status");
        run_edges(10, saw);
        check("dropout valid", saw, 0);

        // ---------------- Reset during CRC ----------------
        apply_reset();
        dna_i = DNA_NOM;
        repeat (24) tick();                       // edge 4 enters CRC, +20
        check("midcrc busy", busy, 1);
        rd_req  = 1'b1;
        rd_addr = 2'd3;
        tick();
        rd_req = 1'b0;
        check("midcrc ack before reset", rd_ack, 1);
        reset = 1'b1;
        #2;
        check("async rd_ack", rd_ack, 0);
        check("async busy", busy, 0);
        check("async dna_valid", dna_valid, 0);
        check("async dna_crc", dna_crc, 0);
        tick();
        reset = 1'b0;
        run_edges(60, saw);
        check("restart early valid", saw, 0);
        tick();
        check("restart dna_valid", dna_valid, 1);
        check("restart dna_crc", dna_crc, crc_nom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
